// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- integer register file for the CPU datapath, with a pending-write
// scoreboard.
//
// Two combinational read ports and one clocked write port. Register 0 always
// reads as zero. Each implemented register also has a busy bit:
//   - decode sets it when it issues a long-latency producer (mark_en/mark_addr);
//   - writeback clears it with the write that delivers the result.
// When BYPASS=1, a write in the current cycle is forwarded to both read ports.
// That forwarding also hides the busy bit the write is about to clear.
//
// Parameters:
//   ADDR_WIDTH  register index width
//   DATA_WIDTH  register data width
//   NUM_REGS    implemented registers (2..2**ADDR_WIDTH); higher indices read
//               as zero and ignore writes and marks
//   BYPASS      1 = forward same-cycle write data to the read ports
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   wr_en/wr_addr/wr_data  writeback write port (also clears busy)
//   rd_addr1/2             read indices
//   rd_data1/2             read data (combinational)
//   rd_busy1/2             pending-write flag of the addressed register
//   mark_en/mark_addr      decode marks a register busy
//   busy_any               OR of all registered busy bits
//
// Optional debug port, enabled by defining the macro REGFILE_DEBUG_PORT_EN:
//   dbg_addr  -> dbg_data  raw register contents (no bypass)
//   dbg_busy               raw busy vector
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_busy1,
    output logic                  rd_busy2,
    input  logic                  mark_en,
    input  logic [ADDR_WIDTH-1:0] mark_addr,
    output logic                  busy_any
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [NUM_REGS-1:0]   dbg_busy
`endif
);

    localparam int ADDR_SPACE = 2 ** ADDR_WIDTH;

    // The arrays span the whole address space. Entries 0 and NUM_REGS and up
    // are tied to zero, so a raw index needs no extra masking.
    logic [DATA_WIDTH-1:0] regs_vec [ADDR_SPACE];
    logic [ADDR_SPACE-1:0] busy_vec;

    // True for indices 1..NUM_REGS-1.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < (ADDR_WIDTH+1)'(NUM_REGS));
    endfunction

    logic wr_valid;
    logic mark_valid;
    assign wr_valid   = wr_en && in_range(wr_addr);
    assign mark_valid = mark_en && in_range(mark_addr);

    // Storage and busy bit, one instance per implemented register.
    generate
        for (genvar gi = 0; gi < ADDR_SPACE; gi++) begin : gen_reg
            if (gi != 0 && gi < NUM_REGS) begin : g_impl
                logic [DATA_WIDTH-1:0] data_reg;
                logic                  busy_reg;
                logic                  wr_hit;
                logic                  mark_hit;

                assign wr_hit   = wr_en   && (wr_addr   == ADDR_WIDTH'(gi));
                assign mark_hit = mark_en && (mark_addr == ADDR_WIDTH'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        if (wr_hit) begin
                            data_reg <= wr_data;
                        end
                        // A new producer issued on the same edge outranks the
                        // write that retires the old one.
                        if (mark_hit) begin
                            busy_reg <= 1'b1;
                        end else if (wr_hit) begin
                            busy_reg <= 1'b0;
                        end
                    end
                end

                assign regs_vec[gi] = data_reg;
                assign busy_vec[gi] = busy_reg;
            end else begin : g_zero
                assign regs_vec[gi] = '0;
                assign busy_vec[gi] = 1'b0;
            end
        end
    endgenerate

    // Read ports. The outputs are forced to zero while rst_n is low, so a
    // forwarded write cannot leak out during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
            logic [ADDR_WIDTH-1:0] addr;
            logic [DATA_WIDTH-1:0] data;
            logic                  busy;
            logic                  fwd;

            assign addr = (gi == 0) ? rd_addr1 : rd_addr2;
            assign fwd  = (BYPASS != 0) && wr_valid && (wr_addr == addr);

            always_comb begin
                data = '0;
                busy = 1'b0;
                if (rst_n && in_range(addr)) begin
                    data = fwd ? wr_data : regs_vec[addr];
                    busy = busy_vec[addr];
                    // The forwarded write retires the producer, unless a new
                    // mark for the same register lands on the same edge.
                    if (fwd && !(mark_valid && (mark_addr == addr))) begin
                        busy = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign rd_data1 = gen_rd[0].data;
    assign rd_data2 = gen_rd[1].data;
    assign rd_busy1 = gen_rd[0].busy;
    assign rd_busy2 = gen_rd[1].busy;

    // Only implemented bits can ever be set, so a full-width OR is exact.
    assign busy_any = |busy_vec;

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_data = in_range(dbg_addr) ? regs_vec[dbg_addr] : '0;
    assign dbg_busy = busy_vec[NUM_REGS-1:0];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Two instances share the same stimulus:
//   dut_a: NUM_REGS=16, BYPASS=1
//   dut_b: NUM_REGS=32, BYPASS=0
// The table rows carry the expected outputs for dut_a. A reference model
// supplies the expected outputs for dut_b, and for the hand-written sequences.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        mark_en;
    logic [4:0]  mark_addr;

    logic [31:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_b1, a_b2, a_any, b_b1, b_b2, b_any;

    always #5 clk = ~clk;

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(16), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(a_d1), .rd_data2(a_d2),
        .rd_busy1(a_b1), .rd_busy2(a_b2), .mark_en(mark_en), .mark_addr(mark_addr),
        .busy_any(a_any));

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(32), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(b_d1), .rd_data2(b_d2),
        .rd_busy1(b_b1), .rd_busy2(b_b2), .mark_en(mark_en), .mark_addr(mark_addr),
        .busy_any(b_any));

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        any;
    } outs_t;

    typedef struct {
        int    dut;
        outs_t o;
    } sb_t;

    typedef struct {
        logic        rst_n;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        mark_en;
        logic [4:0]  mark_addr;
        outs_t       exp_a;
    } vec_t;

    sb_t   sb_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    // Reference model state.
    int          nr [2] = '{16, 32};
    int          bp [2] = '{1, 0};
    logic [31:0] m_reg  [2][32];
    logic        m_busy [2][32];

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                m_reg[d][r]  = '0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    function automatic outs_t model_out(input int d);
        outs_t       o;
        logic        wv, mv, bv;
        logic [4:0]  a;
        logic [31:0] dv;
        o = '0;
        if (!rst_n) return o;
        wv = wr_en && wr_addr != 0 && int'(wr_addr) < nr[d];
        mv = mark_en && mark_addr != 0 && int'(mark_addr) < nr[d];
        for (int p = 0; p < 2; p++) begin
            a  = (p == 0) ? rd_addr1 : rd_addr2;
            dv = '0;
            bv = 1'b0;
            if (a != 0 && int'(a) < nr[d]) begin
                if (bp[d] != 0 && wv && wr_addr == a) dv = wr_data;
                else dv = m_reg[d][a];
                bv = m_busy[d][a];
                if (bp[d] != 0 && wv && wr_addr == a && !(mv && mark_addr == a)) bv = 1'b0;
            end
            if (p == 0) begin o.d1 = dv; o.b1 = bv; end
            else        begin o.d2 = dv; o.b2 = bv; end
        end
        for (int r = 1; r < 32; r++) o.any = o.any | m_busy[d][r];
        return o;
    endfunction

    task automatic model_edge();
        logic wv, mv;
        if (!rst_n) return;
        for (int d = 0; d < 2; d++) begin
            wv = wr_en && wr_addr != 0 && int'(wr_addr) < nr[d];
            mv = mark_en && mark_addr != 0 && int'(mark_addr) < nr[d];
            if (wv) m_reg[d][wr_addr] = wr_data;
            if (mv) m_busy[d][mark_addr] = 1'b1;
            if (wv && !(mv && mark_addr == wr_addr)) m_busy[d][wr_addr] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop one scoreboard entry and compare it with the matching instance.
    task automatic sb_check(input int idx);
        sb_t   e;
        outs_t act;
        string tag;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e   = sb_q.pop_front();
        act = (e.dut == 0) ? outs_t'{a_d1, a_d2, a_b1, a_b2, a_any}
                           : outs_t'{b_d1, b_d2, b_b1, b_b2, b_any};
        tag = $sformatf("step%0d_%s", idx, (e.dut == 0) ? "a" : "b");
        chk({tag, "_rd_data1"}, act.d1, e.o.d1);
        chk({tag, "_rd_data2"}, act.d2, e.o.d2);
        chk({tag, "_rd_busy1"}, 32'(act.b1), 32'(e.o.b1));
        chk({tag, "_rd_busy2"}, 32'(act.b2), 32'(e.o.b2));
        chk({tag, "_busy_any"}, 32'(act.any), 32'(e.o.any));
    endtask

    // One cycle: drive at the negedge, check 1 time unit later, then advance
    // the model on the rising edge.
    task automatic cycle(input vec_t v, input bit use_tab, input int idx);
        sb_t e;
        rst_n = v.rst_n;
        wr_en = v.wr_en;
        wr_addr = v.wr_addr;
        wr_data = v.wr_data;
        rd_addr1 = v.rd1;
        rd_addr2 = v.rd2;
        mark_en = v.mark_en;
        mark_addr = v.mark_addr;
        if (!rst_n) model_clear();
        #1;
        e.dut = 0; e.o = use_tab ? v.exp_a : model_out(0); sb_q.push_back(e);
        e.dut = 1; e.o = model_out(1);                     sb_q.push_back(e);
        sb_check(idx);
        sb_check(idx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic rn, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic me,
                                input logic [4:0] ma, input logic [31:0] d1,
                                input logic [31:0] d2, input logic b1,
                                input logic b2, input logic an);
        vec_t v;
        v.rst_n = rn; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.rd1 = r1; v.rd2 = r2; v.mark_en = me; v.mark_addr = ma;
        v.exp_a = '{d1, d2, b1, b2, an};
        return v;
    endfunction

    vec_t tab[20];

    initial begin
        //            rst we wa  wdata         r1  r2  me ma   exp d1        exp d2        b1 b2 any
        tab[0]  = mk(1, 1, 5,  32'hDEADBEEF, 5,  5,  0, 0,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tab[1]  = mk(1, 0, 0,  32'h0,        5,  5,  0, 0,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tab[2]  = mk(0, 1, 6,  32'h66,       5,  6,  1, 6,   32'h0,        32'h0,        0, 0, 0);
        tab[3]  = mk(1, 0, 0,  32'h0,        5,  6,  0, 0,   32'h0,        32'h0,        0, 0, 0);
        tab[4]  = mk(1, 1, 0,  32'hFFFFFFFF, 0,  0,  1, 0,   32'h0,        32'h0,        0, 0, 0);
        tab[5]  = mk(1, 0, 0,  32'h0,        0,  0,  0, 0,   32'h0,        32'h0,        0, 0, 0);
        tab[6]  = mk(1, 1, 3,  32'h12345678, 3,  3,  0, 0,   32'h12345678, 32'h12345678, 0, 0, 0);
        tab[7]  = mk(1, 0, 0,  32'h0,        3,  3,  0, 0,   32'h12345678, 32'h12345678, 0, 0, 0);
        tab[8]  = mk(1, 0, 0,  32'h0,        7,  3,  1, 7,   32'h0,        32'h12345678, 0, 0, 0);
        tab[9]  = mk(1, 0, 0,  32'h0,        7,  7,  0, 0,   32'h0,        32'h0,        1, 1, 1);
        tab[10] = mk(1, 1, 7,  32'hA5,       7,  7,  0, 0,   32'hA5,       32'hA5,       0, 0, 1);
        tab[11] = mk(1, 0, 0,  32'h0,        7,  7,  0, 0,   32'hA5,       32'hA5,       0, 0, 0);
        tab[12] = mk(1, 1, 9,  32'h99,       9,  9,  1, 9,   32'h99,       32'h99,       0, 0, 0);
        tab[13] = mk(1, 0, 0,  32'h0,        9,  9,  0, 0,   32'h99,       32'h99,       1, 1, 1);
        tab[14] = mk(1, 1, 10, 32'h1010,     4,  10, 1, 4,   32'h0,        32'h1010,     0, 0, 1);
        tab[15] = mk(1, 0, 0,  32'h0,        4,  10, 0, 0,   32'h0,        32'h1010,     1, 0, 1);
        tab[16] = mk(1, 1, 20, 32'h55,       20, 9,  1, 20,  32'h0,        32'h99,       0, 1, 1);
        tab[17] = mk(1, 0, 0,  32'h0,        20, 4,  0, 0,   32'h0,        32'h0,        0, 1, 1);
        tab[18] = mk(1, 1, 9,  32'hAA,       15, 9,  1, 15,  32'h0,        32'hAA,       0, 0, 1);
        tab[19] = mk(1, 0, 0,  32'h0,        15, 9,  0, 0,   32'h0,        32'hAA,       1, 0, 1);

        // Power-on reset, with the reset state checked through the model.
        model_clear();
        @(negedge clk);
        cycle(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            cycle(tab[i], 1'b1, i);
            $display("vec %0d: wr_en=%0b x%0d=%h rd %0d/%0d mark=%0b x%0d", i,
                     tab[i].wr_en, tab[i].wr_addr, tab[i].wr_data, tab[i].rd1,
                     tab[i].rd2, tab[i].mark_en, tab[i].mark_addr);
        end

        // Write every index (out-of-range ones too), then read everything
        // back. This also retires every busy bit that is still pending.
        for (int r = 1; r < 32; r++) begin
            cycle(mk(1, 1, 5'(r), 32'h01010101 * r, 5'(r), 5'(32 - r), 0, 0,
                     0, 0, 0, 0, 0), 1'b0, 100 + r);
            $display("fill x%0d = %h", r, 32'h01010101 * r);
        end
        for (int r = 0; r < 32; r++) begin
            cycle(mk(1, 0, 0, 0, 5'(r), 5'(31 - r), 0, 0, 0, 0, 0, 0, 0), 1'b0, 200 + r);
            $display("readback x%0d / x%0d", r, 31 - r);
        end

        // A mark on a register that is already busy, then one write, leaves
        // it clear; the mark has no count.
        cycle(mk(1, 0, 0, 0, 12, 0, 1, 12, 0, 0, 0, 0, 0), 1'b0, 300);
        cycle(mk(1, 0, 0, 0, 12, 0, 1, 12, 0, 0, 0, 0, 0), 1'b0, 301);
        cycle(mk(1, 1, 12, 32'hC0DE, 12, 12, 0, 0, 0, 0, 0, 0, 0), 1'b0, 302);
        cycle(mk(1, 0, 0, 0, 12, 12, 0, 0, 0, 0, 0, 0, 0), 1'b0, 303);
        $display("double mark / single write on x12");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
